// File: rtl/rv32_pkg.sv
// Shared integer-core types: register address, data word and write-port source id.
package rv32;

    typedef logic [4:0]  addr_t;
    typedef logic [31:0] word_t;

    typedef enum logic {SRC_EXE, SRC_MEM} src_t;

endpackage

// File: rtl/regfile_ctrl_if.sv
// Bundle of execute/LSU write handshakes, register-file write port and decode hazard queries.
interface regfile_ctrl_if;
    import rv32::*;

    logic  exe_valid;
    logic  exe_ready;
    addr_t exe_addr;
    word_t exe_data;

    logic  mem_valid;
    logic  mem_ready;
    addr_t mem_addr;
    word_t mem_data;

    logic  rd_en;
    addr_t rd_addr;
    word_t rd_data;

    logic  iss_en;
    addr_t iss_addr;
    logic  iss_busy;
    addr_t rs1_addr;
    addr_t rs2_addr;
    logic  rs1_busy;
    logic  rs2_busy;

    // Pipeline side: sources, decode and the register file.
    modport master (
        output exe_valid, exe_addr, exe_data,
        output mem_valid, mem_addr, mem_data,
        output iss_en, iss_addr, rs1_addr, rs2_addr,
        input  exe_ready, mem_ready,
        input  rd_en, rd_addr, rd_data,
        input  iss_busy, rs1_busy, rs2_busy
    );

    modport slave (
        input  exe_valid, exe_addr, exe_data,
        input  mem_valid, mem_addr, mem_data,
        input  iss_en, iss_addr, rs1_addr, rs2_addr,
        output exe_ready, mem_ready,
        output rd_en, rd_addr, rd_data,
        output iss_busy, rs1_busy, rs2_busy
    );

endinterface

// File: rtl/regfile_ctrl_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register x1..x31, three busy lookups.
module scoreboard
    import rv32::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  setEn_i,
    input  addr_t setAddr_i,
    input  logic  clrEn_i,
    input  addr_t clrAddr_i,
    input  addr_t rs1Addr_i,
    input  addr_t rs2Addr_i,
    input  addr_t issAddr_i,
    output logic  rs1Busy_o,
    output logic  rs2Busy_o,
    output logic  issBusy_o
);

    logic [31:1] pending_q;
    logic [31:1] pending_d;
    logic [31:0] pendingAll;

    // Set is applied after clear so an issue colliding with a writeback keeps the bit.
    always_comb begin
        pending_d = pending_q;
        for (int i = 1; i < 32; i++) begin
            if (clrEn_i && (clrAddr_i == addr_t'(i))) pending_d[i] = 1'b0;
            if (setEn_i && (setAddr_i == addr_t'(i))) pending_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    // Bit 0 is hard-wired low so lookups of x0 never report busy.
    assign pendingAll = {pending_q, 1'b0};
    assign rs1Busy_o  = pendingAll[rs1Addr_i];
    assign rs2Busy_o  = pendingAll[rs2Addr_i];
    assign issBusy_o  = pendingAll[issAddr_i];

endmodule

// File: rtl/regfile_ctrl.sv
// Round-robin write-port arbiter between execute and LSU writeback, with registered regfile write.
module regfile_ctrl
    import rv32::*;
(
    input  logic          clk,
    input  logic          reset,
    regfile_ctrl_if.slave bus
);

    src_t  lastSrc_q, lastSrc_d;
    logic  rdEn_q, rdEn_d;
    addr_t rdAddr_q, rdAddr_d;
    word_t rdData_q, rdData_d;

    logic  conflict;
    logic  grantExe;
    logic  grantMem;
    logic  xfer;
    addr_t grantAddr;
    word_t grantData;

    logic  rs1Busy, rs2Busy, issBusy;

    // Under contention the source that lost the previous conflict wins; lastSrc moves only then.
    always_comb begin
        conflict  = bus.exe_valid && bus.mem_valid;
        grantMem  = bus.mem_valid && (!bus.exe_valid || (lastSrc_q == SRC_EXE));
        grantExe  = bus.exe_valid && !grantMem;
        xfer      = grantExe || grantMem;
        grantAddr = grantMem ? bus.mem_addr : bus.exe_addr;
        grantData = grantMem ? bus.mem_data : bus.exe_data;

        lastSrc_d = lastSrc_q;
        rdAddr_d  = rdAddr_q;
        rdData_d  = rdData_q;
        rdEn_d    = xfer && (grantAddr != '0);

        if (conflict) lastSrc_d = grantMem ? SRC_MEM : SRC_EXE;
        if (xfer) begin
            rdAddr_d = grantAddr;
            rdData_d = grantData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lastSrc_q <= SRC_EXE;
            rdEn_q    <= 1'b0;
            rdAddr_q  <= '0;
            rdData_q  <= '0;
        end else begin
            lastSrc_q <= lastSrc_d;
            rdEn_q    <= rdEn_d;
            rdAddr_q  <= rdAddr_d;
            rdData_q  <= rdData_d;
        end
    end

    scoreboard u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .setEn_i   (bus.iss_en),
        .setAddr_i (bus.iss_addr),
        .clrEn_i   (xfer),
        .clrAddr_i (grantAddr),
        .rs1Addr_i (bus.rs1_addr),
        .rs2Addr_i (bus.rs2_addr),
        .issAddr_i (bus.iss_addr),
        .rs1Busy_o (rs1Busy),
        .rs2Busy_o (rs2Busy),
        .issBusy_o (issBusy)
    );

    assign bus.exe_ready = grantExe;
    assign bus.mem_ready = grantMem;
    assign bus.rd_en     = rdEn_q;
    assign bus.rd_addr   = rdAddr_q;
    assign bus.rd_data   = rdData_q;
    assign bus.rs1_busy  = rs1Busy;
    assign bus.rs2_busy  = rs2Busy;
    assign bus.iss_busy  = issBusy;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl with a behavioural register file on the write port.
module tb_regfile_ctrl;
    import rv32::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    word_t rf [32] = '{default: '0};

    regfile_ctrl_if bus ();

    regfile_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register file behind the write port, committing on the edge where rd_en is high.
    always @(posedge clk) begin
        if (bus.rd_en) rf[bus.rd_addr] <= bus.rd_data;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ev, input addr_t ea, input word_t ed,
                                 input logic mv, input addr_t ma, input word_t md,
                                 input logic ie, input addr_t ia);
        bus.exe_valid = ev;
        bus.exe_addr  = ea;
        bus.exe_data  = ed;
        bus.mem_valid = mv;
        bus.mem_addr  = ma;
        bus.mem_data  = md;
        bus.iss_en    = ie;
        bus.iss_addr  = ia;
        #1;
    endtask

    initial begin
        word_t exeData;
        word_t memData;
        logic  expMem;

        reset        = 1'b1;
        bus.rs1_addr = 5'd5;
        bus.rs2_addr = 5'd5;
        applyStimulus(1'b1, 5'd5, 32'hAAAA_0005, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);

        // Reset held two cycles with a source and an issue pending.
        checkOutput("reset_exe_ready_comb", bus.exe_ready, 1'b1);
        tick();
        tick();
        checkOutput("reset_rd_en", bus.rd_en, 1'b0);
        checkOutput("reset_rd_addr", bus.rd_addr, 32'd0);
        checkOutput("reset_rd_data", bus.rd_data, 32'd0);
        checkOutput("reset_rs1_busy", bus.rs1_busy, 1'b0);
        checkOutput("reset_iss_busy", bus.iss_busy, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5);
        checkOutput("post_reset_iss_busy", bus.iss_busy, 1'b0);
        checkOutput("post_reset_rs2_busy", bus.rs2_busy, 1'b0);

        // Single source: issue x5, then execute writes 0xDEADBEEF.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5);
        checkOutput("single_busy_before_issue", bus.rs1_busy, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5);
        checkOutput("single_rs1_busy_pending", bus.rs1_busy, 1'b1);
        checkOutput("single_iss_busy_waw", bus.iss_busy, 1'b1);
        checkOutput("single_exe_ready", bus.exe_ready, 1'b1);
        checkOutput("single_mem_ready", bus.mem_ready, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("single_rd_en", bus.rd_en, 1'b1);
        checkOutput("single_rd_addr", bus.rd_addr, 32'd5);
        checkOutput("single_rd_data", bus.rd_data, 32'hDEAD_BEEF);
        checkOutput("single_rs1_busy_cleared", bus.rs1_busy, 1'b0);
        checkOutput("single_rf_old_value", rf[5], 32'h0);
        tick();
        checkOutput("single_rd_en_drop", bus.rd_en, 1'b0);
        checkOutput("single_rf_new_value", rf[5], 32'hDEAD_BEEF);

        // Contention: exe x1 and mem x2 both valid for four cycles, new data after each accept.
        exeData = 32'h1111_0000;
        memData = 32'h2222_0000;
        for (int i = 0; i < 4; i++) begin
            expMem = (i % 2 == 0);
            applyStimulus(1'b1, 5'd1, exeData, 1'b1, 5'd2, memData, 1'b0, 5'd0);
            checkOutput($sformatf("cont%0d_mem_ready", i), bus.mem_ready, expMem);
            checkOutput($sformatf("cont%0d_exe_ready", i), bus.exe_ready, !expMem);
            tick();
            checkOutput($sformatf("cont%0d_rd_en", i), bus.rd_en, 1'b1);
            checkOutput($sformatf("cont%0d_rd_addr", i), bus.rd_addr, expMem ? 32'd2 : 32'd1);
            checkOutput($sformatf("cont%0d_rd_data", i), bus.rd_data, expMem ? memData : exeData);
            if (expMem) memData = memData + 32'd1;
            else        exeData = exeData + 32'd1;
        end

        // Write to x0: handshake completes without a register-file write.
        bus.rs1_addr = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0);
        checkOutput("x0_mem_ready", bus.mem_ready, 1'b1);
        checkOutput("x0_rs1_busy", bus.rs1_busy, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("x0_rd_en", bus.rd_en, 1'b0);

        // Set/clear collision on x7: the new issue survives the writeback.
        bus.rs2_addr = 5'd7;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
        tick();
        applyStimulus(1'b1, 5'd7, 32'h0000_0077, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
        checkOutput("coll_exe_ready", bus.exe_ready, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("coll_rs2_busy_kept", bus.rs2_busy, 1'b1);
        checkOutput("coll_rd_addr", bus.rd_addr, 32'd7);
        applyStimulus(1'b1, 5'd7, 32'h0000_0078, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("coll_rs2_busy_cleared", bus.rs2_busy, 1'b0);

        // Reset mid-operation: x9 pending, last=MEM, grant to x3, then reset.
        bus.rs1_addr = 5'd9;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        tick();
        applyStimulus(1'b1, 5'd3, 32'h0000_0333, 1'b1, 5'd8, 32'h0000_0888, 1'b0, 5'd0);
        checkOutput("rstmid_conflict_mem_ready", bus.mem_ready, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd3, 32'h0000_0333, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("rstmid_exe_ready", bus.exe_ready, 1'b1);
        tick();
        reset = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("rstmid_rd_en_before", bus.rd_en, 1'b1);
        checkOutput("rstmid_rd_addr_before", bus.rd_addr, 32'd3);
        checkOutput("rstmid_x9_busy_before", bus.rs1_busy, 1'b1);
        tick();
        reset = 1'b0;
        checkOutput("rstmid_rd_en_after", bus.rd_en, 1'b0);
        checkOutput("rstmid_rd_data_after", bus.rd_data, 32'd0);
        checkOutput("rstmid_x9_busy_after", bus.rs1_busy, 1'b0);
        applyStimulus(1'b1, 5'd4, 32'h0000_0444, 1'b1, 5'd6, 32'h0000_0666, 1'b0, 5'd0);
        checkOutput("rstmid_next_conflict_mem", bus.mem_ready, 1'b1);
        checkOutput("rstmid_next_conflict_exe", bus.exe_ready, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("rstmid_next_rd_addr", bus.rd_addr, 32'd6);
        checkOutput("rstmid_next_rd_data", bus.rd_data, 32'h0000_0666);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
